// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default PC geometry and the sequencer FSM encoding.
package cpu_pkg;

   localparam int          PC_W_DEFAULT     = 19;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HALT  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds redirect/halt requests that arrive while an instruction is in flight and
// selects the PC to load when that instruction retires.
module pc_redirect_buf #(
   parameter int PC_W = 19
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            capture,
   input  logic            accept,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt_req,
   input  logic [PC_W-1:0] pc_reg,
   output logic [PC_W-1:0] next_pc,
   output logic            halt_now
);

   logic            redir_pend;
   logic [PC_W-1:0] redir_tgt;
   logic            halt_pend;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         redir_pend <= 1'b0;
         halt_pend  <= 1'b0;
      end else if (accept) begin
         redir_pend <= 1'b0;
         halt_pend  <= 1'b0;
      end else if (capture) begin
         if (br_valid) redir_pend <= 1'b1;
         if (halt_req) halt_pend  <= 1'b1;
      end
   end

   // Target is data only; it is qualified by redir_pend so it needs no reset.
   always_ff @(posedge clk) begin
      if (capture && !accept && br_valid) redir_tgt <= br_target;
   end

   always_comb begin
      next_pc = pc_reg + PC_W'(1);
      if (br_valid)        next_pc = br_target;
      else if (redir_pend) next_pc = redir_tgt;
   end

   assign halt_now = halt_req | halt_pend;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer for a one-instruction-in-flight core: issues fetch strobes and owns the PC.
// Optional retired-instruction counter enabled by defining PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT[PC_W-1:0]
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            retire,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt_req,
   output logic            fetch_en,
   output logic [PC_W-1:0] nextpc,
   output logic            running,
   output logic            halted,
   output logic            proto_err,
   output logic [31:0]     retire_cnt
);

   seq_state_t      state, state_next;
   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] sel_pc;
   logic            in_wait;
   logic            accept;
   logic            halt_now;

   assign in_wait = (state == WAIT);
   assign accept  = in_wait & retire;

   pc_redirect_buf #(.PC_W(PC_W)) u_redirect_buf (
      .clk       (clk),
      .rstn      (rstn),
      .capture   (in_wait),
      .accept    (accept),
      .br_valid  (br_valid),
      .br_target (br_target),
      .halt_req  (halt_req),
      .pc_reg    (pc_reg),
      .next_pc   (sel_pc),
      .halt_now  (halt_now)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (retire) state_next = halt_now ? HALT : ISSUE;
         HALT:    if (start) state_next = ISSUE;
         default: state_next = IDLE;
      endcase
   end

   // fetch_en is registered from the next state so it is high exactly while in ISSUE.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         pc_reg    <= RESET_PC;
         fetch_en  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state    <= state_next;
         fetch_en <= (state_next == ISSUE);
         if (accept) pc_reg <= sel_pc;
         if (retire && !in_wait) proto_err <= 1'b1;
      end
   end

`ifdef PC_SEQ_RETIRE_CNT_EN
   logic [31:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn)       cnt <= 32'd0;
      else if (accept) cnt <= cnt + 32'd1;
   end

   assign retire_cnt = cnt;
`else
   assign retire_cnt = 32'd0;
`endif

   assign nextpc  = pc_reg;
   assign running = (state == ISSUE) || (state == WAIT);
   assign halted  = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected counter values follow PC_SEQ_RETIRE_CNT_EN.
module tb_pc_sequencer;

   localparam int PC_W = 19;

   logic            clk;
   logic            rstn;
   logic            start;
   logic            retire;
   logic            br_valid;
   logic [PC_W-1:0] br_target;
   logic            halt_req;
   logic            fetch_en;
   logic [PC_W-1:0] nextpc;
   logic            running;
   logic            halted;
   logic            proto_err;
   logic [31:0]     retire_cnt;

   int total = 0;
   int bad   = 0;

   pc_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .retire     (retire),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .halt_req   (halt_req),
      .fetch_en   (fetch_en),
      .nextpc     (nextpc),
      .running    (running),
      .halted     (halted),
      .proto_err  (proto_err),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] cnt_exp(input int n);
`ifdef PC_SEQ_RETIRE_CNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Retire in WAIT, confirm the following ISSUE cycle, then step into WAIT.
   task automatic retire_and_check(input string tag, input logic [31:0] exp_pc);
      retire = 1'b1;
      tick();
      retire = 1'b0;
      chk({tag, "_fetch"}, 32'(fetch_en), 32'd1);
      chk({tag, "_pc"}, 32'(nextpc), exp_pc);
      tick();
      chk({tag, "_fetch_off"}, 32'(fetch_en), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; retire = 1'b0;
      br_valid = 1'b0; br_target = '0; halt_req = 1'b0;
      tick();
      tick();
      chk("rst_fetch", 32'(fetch_en), 32'd0);
      chk("rst_pc", 32'(nextpc), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_err", 32'(proto_err), 32'd0);
      chk("rst_cnt", retire_cnt, 32'd0);
      rstn = 1'b1;
      tick();

      // Stray retire in IDLE and inputs ignored in IDLE
      retire = 1'b1; br_valid = 1'b1; br_target = 19'h00abc; halt_req = 1'b1;
      tick();
      retire = 1'b0; br_valid = 1'b0; halt_req = 1'b0;
      chk("idle_err", 32'(proto_err), 32'd1);
      chk("idle_pc", 32'(nextpc), 32'd0);
      chk("idle_running", 32'(running), 32'd0);
      chk("idle_cnt", retire_cnt, 32'd0);
      tick();
      chk("err_sticky", 32'(proto_err), 32'd1);

      // Start -> fetch at pc 0
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_fetch", 32'(fetch_en), 32'd1);
      chk("start_pc", 32'(nextpc), 32'd0);
      tick();
      chk("wait_fetch", 32'(fetch_en), 32'd0);
      chk("wait_running", 32'(running), 32'd1);

      // Sequential retires: 1,2,3,4
      for (int k = 1; k <= 4; k++) begin
         tick();
         retire_and_check("seq", 32'(k));
      end

      // Redirect latched in WAIT, applied on later retire; no combinational path
      br_valid = 1'b1; br_target = 19'h01234;
      tick();
      br_valid = 1'b0;
      chk("redir_hold_pc", 32'(nextpc), 32'd4);
      tick();
      retire_and_check("redir", 32'h01234);

      // Last branch wins
      br_valid = 1'b1; br_target = 19'h00010;
      tick();
      br_target = 19'h00020;
      tick();
      br_valid = 1'b0;
      retire_and_check("redir_last", 32'h00020);

      // Same-cycle branch and retire, then wrap on increment
      br_valid = 1'b1; br_target = 19'h7ffff;
      retire_and_check("same_cyc", 32'h7ffff);
      br_valid = 1'b0;
      retire_and_check("wrap", 32'h00000);

      // Position at pc 5, then halt
      br_valid = 1'b1; br_target = 19'h00005;
      retire_and_check("to5", 32'h00005);
      br_valid = 1'b0;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      tick();
      retire = 1'b1;
      tick();
      retire = 1'b0;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_fetch", 32'(fetch_en), 32'd0);
      chk("halt_pc", 32'(nextpc), 32'd6);
      chk("halt_running", 32'(running), 32'd0);
      chk("halt_cnt", retire_cnt, cnt_exp(10));
      br_valid = 1'b1; br_target = 19'h00055; halt_req = 1'b1;
      tick();
      br_valid = 1'b0; halt_req = 1'b0;
      chk("halt_stay_fetch", 32'(fetch_en), 32'd0);
      chk("halt_stay_pc", 32'(nextpc), 32'd6);

      // Resume from HALT; branch seen in HALT must not be latched
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("resume_fetch", 32'(fetch_en), 32'd1);
      chk("resume_pc", 32'(nextpc), 32'd6);
      chk("resume_halted", 32'(halted), 32'd0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_wait_fetch", 32'(fetch_en), 32'd0);
      chk("start_in_wait_run", 32'(running), 32'd1);
      retire_and_check("post_halt", 32'd7);

      // Retire + branch + halt in one cycle: redirect then HALT
      retire = 1'b1; br_valid = 1'b1; br_target = 19'h00040; halt_req = 1'b1;
      tick();
      retire = 1'b0; br_valid = 1'b0; halt_req = 1'b0;
      chk("triple_halted", 32'(halted), 32'd1);
      chk("triple_pc", 32'(nextpc), 32'h40);
      chk("triple_fetch", 32'(fetch_en), 32'd0);
      chk("triple_cnt", retire_cnt, cnt_exp(12));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("triple_resume_pc", 32'(nextpc), 32'h40);
      tick();

      // Reset in WAIT with a pending redirect
      br_valid = 1'b1; br_target = 19'h00300;
      tick();
      br_valid = 1'b0;
      rstn = 1'b0;
      tick();
      chk("mid_rst_pc", 32'(nextpc), 32'd0);
      chk("mid_rst_running", 32'(running), 32'd0);
      chk("mid_rst_err", 32'(proto_err), 32'd0);
      chk("mid_rst_fetch", 32'(fetch_en), 32'd0);
      chk("mid_rst_cnt", retire_cnt, 32'd0);
      rstn = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_fetch", 32'(fetch_en), 32'd1);
      chk("restart_pc", 32'(nextpc), 32'd0);
      tick();
      retire_and_check("no_stale_redir", 32'd1);
      chk("final_cnt", retire_cnt, cnt_exp(1));
      chk("final_err", 32'(proto_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
